ifu_prefetch: RTL



---
 rtl/ifu_pkg.sv | 13 +
 rtl/ifu_fifo.sv | 49 ++++
 rtl/ifu_prefetch.sv | 86 ++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch queue: DEPTH-entry synchronous FIFO of {address, instruction} pairs.
// Flush empties the queue in one cycle; a push into a full queue is legal only alongside a pop.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_data,
  output fetch_entry_t rd_data,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: an empty count hides every slot.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: owns the fetch PC, queues ROM words and hands them to decode.
// Define IFU_BYPASS_EN to forward the ROM word straight to decode when the queue is empty.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int              DEPTH      = 4,
  parameter logic [XLEN-1:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INST   = INST_NOP,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] rom_addr_o,
  input  logic [XLEN-1:0] rom_inst_i,
  input  logic            jump_en_i,
  input  logic [XLEN-1:0] jump_addr_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_addr_o,
  input  logic            inst_ready_i
);

  logic [XLEN-1:0] fetch_pc;
  fetch_entry_t    head;
  fetch_entry_t    wr_entry;
  logic            fifo_full;
  logic            fifo_empty;
  logic [AW:0]     fifo_count;
  logic            pop;
  logic            push;
  logic            fifo_push;
  logic            fifo_pop;

  assign wr_entry = '{addr: fetch_pc, inst: rom_inst_i};

`ifdef IFU_BYPASS_EN
  logic bypass;

  assign bypass       = fifo_empty & ~jump_en_i;
  assign inst_valid_o = (fifo_count != '0) | bypass;
  assign pop          = inst_valid_o & inst_ready_i;
  assign fifo_pop     = pop & ~fifo_empty;
  assign push         = ~jump_en_i & (~fifo_full | pop);
  // A bypassed word taken by decode never enters the queue, but the PC still advances.
  assign fifo_push    = push & ~(bypass & inst_ready_i);
  assign inst_o       = !fifo_empty ? head.inst : (bypass ? rom_inst_i : NOP_INST);
  assign inst_addr_o  = !fifo_empty ? head.addr : (bypass ? fetch_pc : '0);
`else
  assign inst_valid_o = (fifo_count != '0);
  assign pop          = inst_valid_o & inst_ready_i;
  assign fifo_pop     = pop;
  // Full queue with a simultaneous pop still pushes, keeping one word per cycle.
  assign push         = ~jump_en_i & (~fifo_full | pop);
  assign fifo_push    = push;
  assign inst_o       = fifo_empty ? NOP_INST : head.inst;
  assign inst_addr_o  = fifo_empty ? '0 : head.addr;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= RESET_ADDR;
    end else if (jump_en_i) begin
      fetch_pc <= {jump_addr_i[XLEN-1:2], 2'b00};
    end else if (push) begin
      fetch_pc <= fetch_pc + PC_STEP;
    end
  end

  assign rom_addr_o = fetch_pc;

  ifu_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (jump_en_i),
    .wr_data (wr_entry),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule
